// File: rtl/sopc_bus_pkg.sv
// sopc_bus_pkg: shared FSM state type, default widths and latency-counter sizing for the SOPC memory arbiter
package sopc_bus_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} arb_state_t;
    localparam int DEF_NUM_MST = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SLV_LAT = 1;
    function automatic int lat_cnt_w(input int lat);
        return $clog2(lat + 1);
    endfunction
endpackage

// File: rtl/sopc_rr_arbiter.sv
// sopc_rr_arbiter: round-robin request picker with exclude mask; OPENMIPS_ARB_FIXED_PRIO_EN selects fixed lowest-index priority
module sopc_rr_arbiter #(
    parameter int NUM_MST = 2,
    localparam int IW = $clog2(NUM_MST)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MST-1:0] req,
    input  logic [NUM_MST-1:0] excl,
    input  logic               adv,
    output logic [NUM_MST-1:0] gnt,
    output logic [IW-1:0]      idx
);
    logic [NUM_MST-1:0] elig;
    logic [IW-1:0]      ptr;
    logic               found;
    int                 k;
    assign elig = req & ~excl;
`ifdef OPENMIPS_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv)
            ptr <= (int'(idx) == NUM_MST - 1) ? '0 : idx + 1'b1;
    end
`endif
    always_comb begin
        found = 1'b0;
        idx   = '0;
        k     = 0;
        for (int i = 0; i < NUM_MST; i++) begin
            k = (int'(ptr) + i) % NUM_MST;
            if (!found && elig[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
        gnt = found ? NUM_MST'(1) << idx : '0;
    end
endmodule

// File: rtl/sopc_mem_arbiter.sv
// sopc_mem_arbiter: N-master to 1-slave RAM arbiter (issue/wait/ack FSM); OPENMIPS_ARB_FIXED_PRIO_EN selects fixed priority
module sopc_mem_arbiter
    import sopc_bus_pkg::*;
#(
    parameter int NUM_MST = DEF_NUM_MST,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SEL_W   = DATA_W / 8,
    parameter int SLV_LAT = DEF_SLV_LAT
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_MST-1:0]        i_m_ce,
    input  logic [NUM_MST-1:0]        i_m_we,
    input  logic [NUM_MST*ADDR_W-1:0] i_m_addr,
    input  logic [NUM_MST*DATA_W-1:0] i_m_wdata,
    input  logic [NUM_MST*SEL_W-1:0]  i_m_sel,
    output logic [DATA_W-1:0]         o_m_rdata,
    output logic [NUM_MST-1:0]        o_m_ack,
    output logic [NUM_MST-1:0]        o_m_stall,
    output logic                      o_s_ce,
    output logic                      o_s_we,
    output logic [ADDR_W-1:0]         o_s_addr,
    output logic [DATA_W-1:0]         o_s_wdata,
    output logic [SEL_W-1:0]          o_s_sel,
    input  logic [DATA_W-1:0]         i_s_rdata
);
    localparam int IW = $clog2(NUM_MST);
    localparam int CW = lat_cnt_w(SLV_LAT);
    arb_state_t         state;
    logic [CW-1:0]      cnt;
    logic [NUM_MST-1:0] gnt, arb_gnt, excl;
    logic [IW-1:0]      arb_idx;
    logic               adv;
    assign excl      = (state == DONE) ? gnt : '0;
    assign adv       = (state == IDLE || state == DONE) && |arb_gnt;
    assign o_m_stall = i_m_ce & ~o_m_ack;
    sopc_rr_arbiter #(.NUM_MST(NUM_MST)) u_arb (
        .clk (i_clk),
        .rst (i_rst),
        .req (i_m_ce),
        .excl(excl),
        .adv (adv),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            o_m_ack   <= '0;
            o_m_rdata <= '0;
            o_s_ce    <= 1'b0;
            o_s_we    <= 1'b0;
            o_s_addr  <= '0;
            o_s_wdata <= '0;
            o_s_sel   <= '0;
        end else begin
            o_s_ce  <= adv;
            o_m_ack <= '0;
            if (adv) begin
                gnt       <= arb_gnt;
                o_s_we    <= i_m_we[arb_idx];
                o_s_addr  <= i_m_addr[arb_idx*ADDR_W +: ADDR_W];
                o_s_wdata <= i_m_wdata[arb_idx*DATA_W +: DATA_W];
                o_s_sel   <= i_m_sel[arb_idx*SEL_W +: SEL_W];
            end
            case (state)
                IDLE, DONE: state <= adv ? ISSUE : IDLE;
                ISSUE: begin
                    state <= o_s_we ? DONE : WAIT;
                    cnt   <= CW'(SLV_LAT - 1);
                    if (o_s_we)
                        o_m_ack <= gnt;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        o_m_ack   <= gnt;
                        o_m_rdata <= i_s_rdata;
                    end else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// tb_sopc_mem_arbiter: directed checks on a 2-master SLV_LAT=1 instance and a 3-master SLV_LAT=3 instance
module tb_sopc_mem_arbiter;
`ifdef OPENMIPS_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_run = 0, n_fail = 0;
    always #5 clk = ~clk;

    logic [1:0]  a_ce, a_we, a_ack, a_stall;
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_sel;
    logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
    logic        a_sce, a_swe;
    logic [3:0]  a_ssel;
    logic [31:0] mem [256];

    logic [2:0]  b_ce, b_we, b_ack, b_stall;
    logic [95:0] b_addr, b_wdata;
    logic [11:0] b_sel;
    logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
    logic        b_sce, b_swe;
    logic [3:0]  b_ssel;
    logic [31:0] pb0, pb1, pb2;

    sopc_mem_arbiter #(.NUM_MST(2), .ADDR_W(32), .DATA_W(32), .SLV_LAT(1)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_m_ce(a_ce), .i_m_we(a_we), .i_m_addr(a_addr),
        .i_m_wdata(a_wdata), .i_m_sel(a_sel), .o_m_rdata(a_rdata), .o_m_ack(a_ack),
        .o_m_stall(a_stall), .o_s_ce(a_sce), .o_s_we(a_swe), .o_s_addr(a_saddr),
        .o_s_wdata(a_swdata), .o_s_sel(a_ssel), .i_s_rdata(a_srdata)
    );
    sopc_mem_arbiter #(.NUM_MST(3), .ADDR_W(32), .DATA_W(32), .SLV_LAT(3)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_m_ce(b_ce), .i_m_we(b_we), .i_m_addr(b_addr),
        .i_m_wdata(b_wdata), .i_m_sel(b_sel), .o_m_rdata(b_rdata), .o_m_ack(b_ack),
        .o_m_stall(b_stall), .o_s_ce(b_sce), .o_s_we(b_swe), .o_s_addr(b_saddr),
        .o_s_wdata(b_swdata), .o_s_sel(b_ssel), .i_s_rdata(b_srdata)
    );

    // Byte-writable RAM, one-cycle read; off-access cycles return a poison word
    always @(posedge clk) begin
        if (rst_a) begin
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'hAAAA_BBBB;
        end else if (a_sce && a_swe) begin
            for (int i = 0; i < 4; i++)
                if (a_ssel[i]) mem[a_saddr[9:2]][i*8 +: 8] <= a_swdata[i*8 +: 8];
        end
        a_srdata <= (a_sce && !a_swe) ? mem[a_saddr[9:2]] : 32'hBAD1_BAD1;
    end

    // Three-cycle read pipeline returning an address-tagged word
    always @(posedge clk) begin
        pb0 <= (b_sce && !b_swe) ? {16'hB000, 8'h00, b_saddr[7:0]} : 32'hBAD0_0000;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign b_srdata = pb2;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int g, n_ce, n_ack;
        logic [1:0] ack_seen;
        rst_a = 1'b1; rst_b = 1'b1;
        a_ce = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_sel = '0;
        b_ce = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_sel = '0;
        tick; tick;
        chk("rst_ack", a_ack, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_sce", a_sce, 0);
        chk("rst_saddr", a_saddr, 0);
        chk("rst_b_ack", b_ack, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick;
        // single read, master1
        a_ce = 2'b10; a_addr[63:32] = 32'h10; a_sel = 8'hF0;
        #1 chk("rd_stall_n", a_stall, 2'b10);
        tick;
        chk("rd_sce", a_sce, 1);
        chk("rd_saddr", a_saddr, 32'h10);
        chk("rd_swe", a_swe, 0);
        chk("rd_stall_n1", a_stall, 2'b10);
        tick;
        chk("rd_ack_n2", a_ack, 0);
        chk("rd_stall_n2", a_stall, 2'b10);
        tick;
        chk("rd_ack", a_ack, 2'b10);
        chk("rd_data", a_rdata, 32'hDEAD_BEEF);
        chk("rd_stall_ack", a_stall, 2'b00);
        a_ce = 2'b00;
        tick;
        chk("rd_idle_ack", a_ack, 0);
        chk("rd_idle_sce", a_sce, 0);
        // byte-select write, master0
        a_ce = 2'b01; a_we = 2'b01; a_addr[31:0] = 32'h20; a_wdata[31:0] = 32'h1234_5678; a_sel[3:0] = 4'b0011;
        tick;
        chk("wr_sce", a_sce, 1);
        chk("wr_swe", a_swe, 1);
        chk("wr_ssel", a_ssel, 4'b0011);
        chk("wr_swdata", a_swdata, 32'h1234_5678);
        tick;
        chk("wr_ack", a_ack, 2'b01);
        chk("wr_rdata_kept", a_rdata, 32'hDEAD_BEEF);
        a_ce = 2'b00; a_we = 2'b00;
        tick;
        a_ce = 2'b01;
        tick; tick; tick;
        chk("wr_rb_ack", a_ack, 2'b01);
        chk("wr_rb_data", a_rdata, 32'hAAAA_5678);
        a_ce = 2'b00;
        tick;
        // contention: both masters read continuously
        a_ce = 2'b11; a_addr = {32'h20, 32'h10};
        for (int t = 0; t < 4; t++) begin
            g = FIXED ? t % 2 : (t + 1) % 2;
            tick;
            chk("cont_sce", a_sce, 1);
            chk("cont_saddr", a_saddr, g ? 32'h20 : 32'h10);
            tick; tick;
            chk("cont_ack", a_ack, 2'b01 << g);
            chk("cont_rdata", a_rdata, g ? 32'hAAAA_5678 : 32'hDEAD_BEEF);
        end
        a_ce = 2'b00;
        tick;
        // lone requester drops ce on its ack
        a_ce = 2'b01; a_addr[31:0] = 32'h10;
        n_ce = 0; n_ack = 0; ack_seen = '0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (a_sce) n_ce++;
            if (a_ack != 0) begin
                n_ack++;
                ack_seen = a_ack;
                a_ce = 2'b00;
            end
        end
        chk("lone_sce_cnt", n_ce, 1);
        chk("lone_ack_cnt", n_ack, 1);
        chk("lone_ack_val", ack_seen, 2'b01);
        // SLV_LAT=3 read, master2
        b_ce = 3'b100; b_addr[95:64] = 32'h44;
        tick;
        chk("l3_sce", b_sce, 1);
        chk("l3_saddr", b_saddr, 32'h44);
        tick; tick; tick;
        chk("l3_ack_early", b_ack, 0);
        tick;
        chk("l3_ack", b_ack, 3'b100);
        chk("l3_rdata", b_rdata, 32'hB000_0044);
        b_ce = 3'b000;
        tick;
        // reset during the second WAIT cycle
        b_ce = 3'b010; b_addr[63:32] = 32'h48;
        tick; tick; tick;
        rst_b = 1'b1; b_ce = 3'b000;
        tick;
        chk("mr_ack", b_ack, 0);
        chk("mr_sce", b_sce, 0);
        chk("mr_swe", b_swe, 0);
        chk("mr_saddr", b_saddr, 0);
        chk("mr_ssel", b_ssel, 0);
        chk("mr_rdata", b_rdata, 0);
        rst_b = 1'b0;
        n_ce = 0; n_ack = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            if (b_sce) n_ce++;
            if (b_ack != 0) n_ack++;
        end
        chk("mr_no_sce", n_ce, 0);
        chk("mr_no_ack", n_ack, 0);
        b_ce = 3'b101; b_addr[31:0] = 32'h50; b_addr[95:64] = 32'h58;
        tick;
        chk("mr_next_sce", b_sce, 1);
        chk("mr_next_saddr", b_saddr, 32'h50);
        tick; tick; tick; tick;
        chk("mr_next_ack", b_ack, 3'b001);
        chk("mr_next_rdata", b_rdata, 32'hB000_0050);
        tick;
        chk("mr_b2b_sce", b_sce, 1);
        chk("mr_b2b_saddr", b_saddr, 32'h58);
        tick; tick; tick; tick;
        chk("mr_b2b_ack", b_ack, 3'b100);
        chk("mr_b2b_rdata", b_rdata, 32'hB000_0058);
        b_ce = 3'b000;
        tick;
        // three masters writing continuously
        b_ce = 3'b111; b_we = 3'b111; b_addr = {32'h68, 32'h64, 32'h60}; b_sel = 12'hFFF;
        for (int t = 0; t < 4; t++) begin
            g = FIXED ? t % 2 : t % 3;
            tick;
            chk("w3_sce", b_sce, 1);
            chk("w3_saddr", b_saddr, 32'h60 + 32'(4 * g));
            tick;
            chk("w3_ack", b_ack, 3'b001 << g);
        end
        b_ce = 3'b000; b_we = 3'b000;
        tick;
        // masters 1 and 2 only
        b_ce = 3'b110; b_we = 3'b110;
        for (int t = 0; t < 4; t++) begin
            g = 1 + t % 2;
            tick;
            chk("w12_saddr", b_saddr, 32'h60 + 32'(4 * g));
            tick;
            chk("w12_ack", b_ack, 3'b001 << g);
        end
        b_ce = 3'b000; b_we = 3'b000;
        tick;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
